// File: rtl/seq_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_comparator_pkg
// Purpose  : FSM states, cascade record and sizing helpers shared by the
//            nibble-serial magnitude comparator.
// Revision : 1.0 - initial release
// ============================================================================
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cascade_t;

  // Starting point of every compare: "equal so far"
  localparam cascade_t CASCADE_RESET = '{g: 1'b0, e: 1'b1, l: 1'b0};

  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparator.sv
`default_nettype none
// ============================================================================
// Module   : comparator
// Purpose  : 4-bit cascadable magnitude slice; equal nibbles defer to the
//            cascade inputs from the less significant slices.
// Revision : 1.0 - initial release
// ============================================================================
module comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       g_in,
  input  logic       e_in,
  input  logic       l_in,
  output logic       g_out,
  output logic       e_out,
  output logic       l_out
);

  always_comb begin
    g_out = g_in;
    e_out = e_in;
    l_out = l_in;
    if (a > b) begin
      g_out = 1'b1;
      e_out = 1'b0;
      l_out = 1'b0;
    end else if (a < b) begin
      g_out = 1'b0;
      e_out = 1'b0;
      l_out = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : seq_comparator
// Purpose  : Nibble-serial signed/unsigned comparator, LSB nibble first,
//            result after WIDTH/4 RUN cycles.
// Revision : 1.0 - initial release
// ============================================================================
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = idx_width(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             smode_q;
  logic [IDXW-1:0]  idx;
  cascade_t         casc;
  cascade_t         slice_out;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             last;
  logic             accept;

  assign ready  = (state != ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && ready;
  assign last   = (idx == LAST_IDX);

  // Flipping the sign bit of the top nibble maps two's complement onto
  // unsigned ordering, so the same slice serves both modes.
  assign nib_a = a_q[{idx, 2'b00} +: 4] ^ {smode_q & last, 3'b000};
  assign nib_b = b_q[{idx, 2'b00} +: 4] ^ {smode_q & last, 3'b000};

  comparator u_slice (
    .a     (nib_a),
    .b     (nib_b),
    .g_in  (casc.g),
    .e_in  (casc.e),
    .l_in  (casc.l),
    .g_out (slice_out.g),
    .e_out (slice_out.e),
    .l_out (slice_out.l)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN:  if (last)  next_state = ST_DONE;
      ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      smode_q <= 1'b0;
      idx     <= '0;
      casc    <= CASCADE_RESET;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      smode_q <= signed_mode;
      idx     <= '0;
      casc    <= CASCADE_RESET;
    end else if (state == ST_RUN) begin
      casc <= slice_out;
      if (last) begin
        gt <= slice_out.g;
        eq <= slice_out.e;
        lt <= slice_out.l;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_comparator
// Purpose  : Directed self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_comparator;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ready, done, gt, eq, lt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seq_comparator #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic s);
    if (x == y) return 3'b010;
    if (s) return ($signed(x) > $signed(y)) ? 3'b100 : 3'b001;
    return (x > y) ? 3'b100 : 3'b001;
  endfunction

  // Reference model: a busy countdown plus arithmetic compare of the captured operands
  int               m_left = 0;
  bit               m_done = 1'b0;
  logic [2:0]       m_res  = 3'b000;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  logic             m_s = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_res  = 3'b000;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = ref_cmp(m_a, m_b, m_s);
        end
      end else if (start) begin
        m_a    = a;
        m_b    = b;
        m_s    = signed_mode;
        m_left = NIB;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_done",  {31'd0, done},  {31'd0, m_done});
      chk("model_ready", {31'd0, ready}, {31'd0, (m_left == 0)});
      chk("model_res",   {29'd0, gt, eq, lt}, {29'd0, m_res});
    end
  end

  task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic s, input logic [2:0] exp, input string nm);
    int k;
    @(negedge clk);
    a = av; b = bv; signed_mode = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, NIB);
    chk({nm, "_result"}, {29'd0, gt, eq, lt}, {29'd0, exp});
  endtask

  initial begin
    int ndone;
    int pos[$];

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_done",  {31'd0, done},  32'd0);
    chk("reset_res",   {29'd0, gt, eq, lt}, 32'd0);
    rst = 1'b0;

    run_cmp(16'h8001, 16'h0001, 1'b0, 3'b100, "msb_gt");
    run_cmp(16'h5555, 16'h5555, 1'b0, 3'b010, "equal");
    run_cmp(16'h0000, 16'h0001, 1'b0, 3'b001, "lsb_lt");
    run_cmp(16'h8000, 16'h0001, 1'b0, 3'b100, "u_8000");
    run_cmp(16'h8000, 16'h0001, 1'b1, 3'b001, "s_8000");
    run_cmp(16'hFFFF, 16'h0001, 1'b1, 3'b001, "s_neg1");
    run_cmp(16'h7FFF, 16'h8000, 1'b1, 3'b100, "s_max_min");
    run_cmp(16'h7FFF, 16'h8000, 1'b0, 3'b001, "u_7fff");
    run_cmp(16'h1240, 16'h1230, 1'b0, 3'b100, "mid_gt");

    // Restart attempt while busy must be ignored
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0009; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("restart_result", {29'd0, gt, eq, lt}, 32'b001);
      end
    end
    chk("restart_single_done", ndone, 1);

    // Reset while nibble 2 is in flight
    @(negedge clk);
    a = 16'h0003; b = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done",  {31'd0, done},  32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_res",   {29'd0, gt, eq, lt}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_cmp(16'h0002, 16'h0003, 1'b0, 3'b001, "after_abort");

    // Start held high: back-to-back compares
    @(negedge clk);
    a = 16'h1234; b = 16'h1233; start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (done) pos.push_back(i);
    end
    start = 1'b0;
    chk("b2b_count", pos.size(), 3);
    if (pos.size() == 3) begin
      chk("b2b_first", pos[0], NIB + 1);
      chk("b2b_gap1", pos[1] - pos[0], NIB + 1);
      chk("b2b_gap2", pos[2] - pos[1], NIB + 1);
    end
    chk("b2b_result", {29'd0, gt, eq, lt}, 32'b100);
    repeat (8) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_comparator.md
SEQ_COMPARATOR -- requirements
Module: seq_comparator

Interface
REQ-001 Parameter WIDTH SHALL be: default 16; operand width; a multiple of 4, minimum 4.
REQ-002 Derived constant NIB SHALL be: WIDTH/4; number of nibbles processed per compare.
REQ-003 Port clk SHALL be: input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit; synchronous, active-high reset.
REQ-005 Port start SHALL be: input, 1 bit; request a compare, sampled on clk rising edge.
REQ-006 Port signed_mode SHALL be: input, 1 bit; 1 = two's-complement compare; latched with start.
REQ-007 Port a SHALL be: input, WIDTH bits; operand A; latched with start.
REQ-008 Port b SHALL be: input, WIDTH bits; operand B; latched with start.
REQ-009 Port ready SHALL be: output, 1 bit; high when start will be accepted.
REQ-010 Port done SHALL be: output, 1 bit; one-cycle pulse when a result is valid.
REQ-011 Port gt SHALL be: output, 1 bit; A > B.
REQ-012 Port eq SHALL be: output, 1 bit; A == B.
REQ-013 Port lt SHALL be: output, 1 bit; A < B.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; ready SHALL be 1 in IDLE and DONE, 0 in RUN.
REQ-015 start with ready=1 SHALL latch a, b and signed_mode, clear nibble index to 0, set the cascade register to g=0/e=1/l=0, and enter RUN.
REQ-016 start with ready=0 SHALL be ignored with no effect on latched operands or progress.
REQ-017 Each RUN cycle SHALL compare nibble[idx] (LSB nibble first), using the cascade register as g_in/e_in/l_in, and register the slice result as the new cascade value.
REQ-018 Slice rule: unequal nibbles SHALL decide the result by nibble magnitude; equal nibbles SHALL pass the cascade inputs through unchanged.
REQ-019 In signed mode, bit 3 of the top nibble (idx=NIB-1) of both operands SHALL be inverted before the compare; all lower nibbles SHALL be compared unsigned.
REQ-020 After the idx=NIB-1 cycle, the FSM SHALL enter DONE and load gt/eq/lt from the final cascade.
REQ-021 done SHALL be high for exactly the DONE cycle; the next state SHALL be IDLE, or RUN if start is asserted in DONE.
REQ-022 Latency: start sampled at edge t SHALL give done=1 in the cycle following edge t+NIB.
REQ-023 gt/eq/lt SHALL be one-hot once the first result is produced.
REQ-024 gt/eq/lt SHALL hold the last result through IDLE and RUN until the next DONE.
REQ-025 The index counter SHALL be ceil(log2(NIB)) bits wide, with a minimum of 1 bit.
REQ-026 The index counter SHALL NOT wrap within a compare.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, idx=0, cascade=0/1/0, done=0, gt=0, eq=0, lt=0, ready=1 on the following cycle.
REQ-028 rst asserted during RUN SHALL abort the compare with no done pulse.
REQ-029 rst SHALL take priority over a simultaneous start.

Structure
REQ-030 The state encoding (IDLE/RUN/DONE) and the cascade reset constant SHALL live in the shared package seq_comparator_pkg.
REQ-031 The per-nibble slice SHALL be the existing 4-bit cascade comparator sub-module comparator (ports a, b, g_in, e_in, l_in, g_out, e_out, l_out), instantiated once.

Verification
REQ-032 The bench SHALL check: unsigned, a=0x8001, b=0x0001 -> gt=1, eq=0, lt=0, done exactly 4 cycles after start.
REQ-033 The bench SHALL check: a=0x5555, b=0x5555 -> eq=1; a=0x0000, b=0x0001 -> lt=1 (LSB-only difference).
REQ-034 The bench SHALL check: a=0x8000, b=0x0001 -> unsigned gt=1; signed_mode=1 -> lt=1.
REQ-035 The bench SHALL check: start re-pulsed with new operands during RUN -> ignored; result still matches the first operands; single done pulse.
REQ-036 The bench SHALL check: rst asserted at idx=2 -> no done, gt/eq/lt=0, ready=1 next cycle; a following compare completes normally.
REQ-037 The bench SHALL check: start held high continuously -> back-to-back compares, done every 5 cycles (NIB+1), ready low only during RUN.
